fanout_fork_ctrl: RTL and testbench

//  Eager-fork controller for one stream source broadcast to up to NUM_DST consumers.

---
 rtl/fanout_fork_ctrl.sv | 77 +++++++
 tb/tb_fanout_fork_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: eager fork of one stream source to NUM_DST consumers.
// Each consumer takes the held token in its own cycle; slot frees once all are done.
module fanout_fork_ctrl #(
  parameter int NUM_DST    = 7,
  parameter int DATA_WIDTH = 17,
  parameter int STALL_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [NUM_DST-1:0]    cfg_en,
  input  logic [NUM_DST-1:0]    cfg_sel,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic [NUM_DST-1:0]    dst_valid,
  input  logic [NUM_DST-1:0]    dst_ready,
  output logic [STALL_W-1:0]    stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic                  r_full;
  logic [NUM_DST-1:0]    r_done;
  logic [DATA_WIDTH-1:0] r_data;
  logic [STALL_W-1:0]    r_stall;

  logic                  w_go;
  logic                  w_clr;
  logic                  w_fin;
  logic                  w_load;
  logic                  w_stall;
  logic [NUM_DST-1:0]    w_active;
  logic [NUM_DST-1:0]    w_acc;

  assign w_go      = clk_en & ~flush;
  assign w_clr     = clk_en & flush;
  assign w_active  = cfg_en & cfg_sel;
  assign dst_valid = {NUM_DST{w_go & r_full}} & w_active & ~r_done;
  assign w_acc     = dst_valid & dst_ready;
  // Inactive destinations count as delivered, so an empty route drops tokens.
  assign w_fin     = &(r_done | w_acc | ~w_active);
  assign src_ready = w_go & (~r_full | w_fin);
  assign w_load    = src_valid & src_ready;
  assign w_stall   = w_go & r_full & ~w_fin;
  assign dst_data  = r_data;
  assign stall_cnt = r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_done  <= '0;
      r_data  <= '0;
      r_stall <= '0;
    end else if (w_clr) begin
      r_full  <= 1'b0;
      r_done  <= '0;
      r_stall <= '0;
    end else if (w_go) begin
      if (w_stall && r_stall != STALL_MAX)
        r_stall <= r_stall + 1'b1;
      if (w_load) begin
        r_full <= 1'b1;
        r_done <= '0;
        r_data <= src_data;
      end else if (r_full && w_fin) begin
        r_full <= 1'b0;
        r_done <= '0;
      end else if (r_full) begin
        r_done <= r_done | w_acc;
      end
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb_fanout_fork_ctrl: directed scenarios plus randomized traffic
// checked against a per-destination delivery model.
module tb_fanout_fork_ctrl;

  localparam int ND = 7;
  localparam int DW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          flush = 1'b0;
  logic [ND-1:0] cfg_en = '0;
  logic [ND-1:0] cfg_sel = '0;
  logic [ND-1:0] dst_ready = '0;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;

  logic          src_ready, src_ready4;
  logic [DW-1:0] dst_data, dst_data4;
  logic [ND-1:0] dst_valid, dst_valid4;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt4;

  int n_pass = 0;
  int n_total = 0;

  // reference model: token slot, set of destinations already served
  bit            m_full = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit [ND-1:0]   m_got = '0;
  int            m_st = 0;
  int            m_st4 = 0;

  logic [ND-1:0] e_valid;
  logic          e_rdy;
  logic          e_fin;

  always #5 clk = ~clk;

  fanout_fork_ctrl #(.NUM_DST(ND), .DATA_WIDTH(DW), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
    .stall_cnt(stall_cnt)
  );

  fanout_fork_ctrl #(.NUM_DST(ND), .DATA_WIDTH(DW), .STALL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready4),
    .dst_data(dst_data4), .dst_valid(dst_valid4), .dst_ready(dst_ready),
    .stall_cnt(stall_cnt4)
  );

  task automatic model_clear();
    m_full = 1'b0;
    m_data = '0;
    m_got  = '0;
    m_st   = 0;
    m_st4  = 0;
  endtask

  // Which destinations still owe an acceptance, and is the token finished?
  task automatic eval();
    bit go;
    bit all_done;
    bit want;
    go = clk_en && !flush;
    all_done = 1'b1;
    e_valid = '0;
    for (int i = 0; i < ND; i++) begin
      want = m_full && cfg_en[i] && cfg_sel[i] && !m_got[i];
      e_valid[i] = go && want;
      if (want && !(e_valid[i] && dst_ready[i]))
        all_done = 1'b0;
    end
    e_fin = all_done;
    e_rdy = go && (!m_full || all_done);
  endtask

  task automatic tick();
    eval();
    @(posedge clk);
    if (clk_en && flush) begin
      m_full = 1'b0;
      m_got  = '0;
      m_st   = 0;
      m_st4  = 0;
    end else if (clk_en) begin
      if (m_full && !e_fin) begin
        if (m_st < 65535) m_st++;
        if (m_st4 < 15) m_st4++;
      end
      if (m_full) begin
        if (e_fin) begin
          m_full = 1'b0;
          m_got  = '0;
        end else begin
          m_got = m_got | (e_valid & dst_ready);
        end
      end
      if (src_valid && e_rdy) begin
        m_full = 1'b1;
        m_data = src_data;
        m_got  = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    flush = 1'b0;
    src_valid = 1'b0;
    #1;
    n_total++;
    if (dst_valid !== '0)
      $display("FAIL reset_dst_valid got %h exp 0", dst_valid);
    else n_pass++;
    n_total++;
    if (dst_data !== '0)
      $display("FAIL reset_dst_data got %h exp 0", dst_data);
    else n_pass++;
    n_total++;
    if (stall_cnt !== '0)
      $display("FAIL reset_stall got %h exp 0", stall_cnt);
    else n_pass++;
    n_total++;
    if (src_ready !== 1'b1)
      $display("FAIL reset_src_ready got %b exp 1", src_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_stream();
    cfg_en = 7'h7F;
    cfg_sel = 7'h7F;
    dst_ready = 7'h7F;
    for (int k = 1; k <= 8; k++) begin
      src_valid = 1'b1;
      src_data = 17'(k);
      #1;
      n_total++;
      if (src_ready !== 1'b1)
        $display("FAIL stream_src_ready k=%0d got %b exp 1", k, src_ready);
      else n_pass++;
      n_total++;
      if (dst_valid !== ((k == 1) ? 7'h00 : 7'h7F))
        $display("FAIL stream_dst_valid k=%0d got %h", k, dst_valid);
      else n_pass++;
      if (k > 1) begin
        n_total++;
        if (dst_data !== 17'(k - 1))
          $display("FAIL stream_data k=%0d got %h exp %h", k, dst_data, k - 1);
        else n_pass++;
      end
      tick();
    end
    src_valid = 1'b0;
    #1;
    n_total++;
    if (dst_valid !== 7'h7F || dst_data !== 17'd8)
      $display("FAIL stream_last got %h/%h exp 7f/8", dst_valid, dst_data);
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd0)
      $display("FAIL stream_stall got %0d exp 0", stall_cnt);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (dst_valid !== 7'h00)
      $display("FAIL stream_drain got %h exp 0", dst_valid);
    else n_pass++;
  endtask

  task automatic test_partial();
    cfg_en = 7'h7F;
    cfg_sel = 7'h09;
    dst_ready = 7'h00;
    src_valid = 1'b1;
    src_data = 17'h0AB;
    #1;
    n_total++;
    if (src_ready !== 1'b1)
      $display("FAIL partial_c0_ready got %b exp 1", src_ready);
    else n_pass++;
    tick();
    src_data = 17'h0CD;
    dst_ready = 7'h01;
    #1;
    n_total++;
    if (dst_valid !== 7'h09 || src_ready !== 1'b0 || dst_data !== 17'h0AB)
      $display("FAIL partial_c1 got v=%h r=%b d=%h exp 09/0/0ab",
               dst_valid, src_ready, dst_data);
    else n_pass++;
    tick();
    dst_ready = 7'h00;
    #1;
    n_total++;
    if (dst_valid !== 7'h08 || src_ready !== 1'b0)
      $display("FAIL partial_c2 got v=%h r=%b exp 08/0", dst_valid, src_ready);
    else n_pass++;
    tick();
    dst_ready = 7'h08;
    #1;
    n_total++;
    if (dst_valid !== 7'h08 || src_ready !== 1'b1)
      $display("FAIL partial_c3 got v=%h r=%b exp 08/1", dst_valid, src_ready);
    else n_pass++;
    tick();
    src_valid = 1'b0;
    dst_ready = 7'h00;
    #1;
    n_total++;
    if (dst_valid !== 7'h09 || dst_data !== 17'h0CD || stall_cnt !== 16'd2)
      $display("FAIL partial_c4 got v=%h d=%h s=%0d exp 09/0cd/2",
               dst_valid, dst_data, stall_cnt);
    else n_pass++;
    dst_ready = 7'h09;
    tick();
    #1;
    n_total++;
    if (dst_valid !== 7'h00 || stall_cnt !== 16'd2)
      $display("FAIL partial_c5 got v=%h s=%0d exp 00/2", dst_valid, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_no_active();
    cfg_en = 7'h00;
    cfg_sel = 7'h7F;
    for (int k = 0; k < 5; k++) begin
      src_valid = 1'b1;
      src_data = 17'($urandom);
      dst_ready = 7'($urandom);
      #1;
      n_total++;
      if (src_ready !== 1'b1 || dst_valid !== 7'h00)
        $display("FAIL noact k=%0d got r=%b v=%h exp 1/00", k, src_ready, dst_valid);
      else n_pass++;
      tick();
    end
    src_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    cfg_en = 7'h7F;
    cfg_sel = 7'h7F;
    dst_ready = 7'h00;
    src_valid = 1'b1;
    src_data = 17'h155;
    tick();
    src_valid = 1'b0;
    dst_ready = 7'h7B;
    #1;
    n_total++;
    if (dst_valid !== 7'h7F)
      $display("FAIL flush_held got %h exp 7f", dst_valid);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (dst_valid !== 7'h04 || src_ready !== 1'b0)
      $display("FAIL flush_pending got v=%h r=%b exp 04/0", dst_valid, src_ready);
    else n_pass++;
    flush = 1'b1;
    #1;
    n_total++;
    if (dst_valid !== 7'h00 || src_ready !== 1'b0)
      $display("FAIL flush_during got v=%h r=%b exp 00/0", dst_valid, src_ready);
    else n_pass++;
    tick();
    flush = 1'b0;
    dst_ready = 7'h7F;
    #1;
    n_total++;
    if (dst_valid !== 7'h00 || stall_cnt !== 16'd0 || src_ready !== 1'b1)
      $display("FAIL flush_after got v=%h s=%0d r=%b exp 00/0/1",
               dst_valid, stall_cnt, src_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_clk_en();
    logic [15:0] snap;
    cfg_en = 7'h7F;
    cfg_sel = 7'h7F;
    dst_ready = 7'h00;
    src_valid = 1'b1;
    src_data = 17'h1F0F;
    tick();
    src_valid = 1'b0;
    #1;
    n_total++;
    if (dst_valid !== 7'h7F)
      $display("FAIL clken_held got %h exp 7f", dst_valid);
    else n_pass++;
    tick();
    snap = 16'(m_st);
    clk_en = 1'b0;
    dst_ready = 7'h7F;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if (dst_valid !== 7'h00 || src_ready !== 1'b0 ||
          stall_cnt !== snap || dst_data !== 17'h1F0F)
        $display("FAIL clken_frozen k=%0d got v=%h r=%b s=%0d d=%h exp 00/0/%0d/1f0f",
                 k, dst_valid, src_ready, stall_cnt, dst_data, snap);
      else n_pass++;
      tick();
    end
    clk_en = 1'b1;
    #1;
    n_total++;
    if (dst_valid !== 7'h7F || src_ready !== 1'b1)
      $display("FAIL clken_resume got v=%h r=%b exp 7f/1", dst_valid, src_ready);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (dst_valid !== 7'h00)
      $display("FAIL clken_done got %h exp 00", dst_valid);
    else n_pass++;
  endtask

  task automatic test_saturate();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cfg_en = 7'h7F;
    cfg_sel = 7'h7F;
    dst_ready = 7'h7E;
    src_valid = 1'b1;
    src_data = 17'h0F0F0;
    tick();
    src_valid = 1'b0;
    repeat (20) tick();
    #1;
    n_total++;
    if (stall_cnt4 !== 4'd15)
      $display("FAIL sat_stall4 got %0d exp 15", stall_cnt4);
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd20)
      $display("FAIL sat_stall16 got %0d exp 20", stall_cnt);
    else n_pass++;
    n_total++;
    if (dst_valid !== 7'h01)
      $display("FAIL sat_pending got %h exp 01", dst_valid);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (dst_valid !== 7'h00 || dst_data !== '0 || stall_cnt !== '0 ||
        stall_cnt4 !== '0 || src_ready !== 1'b1)
      $display("FAIL async_reset got v=%h d=%h s=%0d s4=%0d r=%b",
               dst_valid, dst_data, stall_cnt, stall_cnt4, src_ready);
    else n_pass++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (!m_full && ($urandom % 8) == 0) begin
        cfg_en = 7'($urandom | $urandom);
        cfg_sel = 7'($urandom | $urandom);
      end
      clk_en = ($urandom % 10) != 0;
      flush = ($urandom % 25) == 0;
      src_valid = ($urandom % 4) != 0;
      src_data = 17'($urandom);
      dst_ready = 7'($urandom);
      #1;
      eval();
      n_total++;
      if (dst_valid !== e_valid)
        $display("FAIL rnd_dst_valid k=%0d got %h exp %h", k, dst_valid, e_valid);
      else n_pass++;
      n_total++;
      if (src_ready !== e_rdy)
        $display("FAIL rnd_src_ready k=%0d got %b exp %b", k, src_ready, e_rdy);
      else n_pass++;
      n_total++;
      if (dst_data !== m_data)
        $display("FAIL rnd_dst_data k=%0d got %h exp %h", k, dst_data, m_data);
      else n_pass++;
      n_total++;
      if (stall_cnt !== 16'(m_st) || stall_cnt4 !== 4'(m_st4))
        $display("FAIL rnd_stall k=%0d got %0d/%0d exp %0d/%0d",
                 k, stall_cnt, stall_cnt4, m_st, m_st4);
      else n_pass++;
      n_total++;
      if (dst_valid4 !== e_valid || src_ready4 !== e_rdy || dst_data4 !== m_data)
        $display("FAIL rnd_narrow k=%0d got v=%h r=%b d=%h exp %h/%b/%h",
                 k, dst_valid4, src_ready4, dst_data4, e_valid, e_rdy, m_data);
      else n_pass++;
      tick();
    end
    clk_en = 1'b1;
    flush = 1'b0;
    src_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_partial();
    test_no_active();
    test_flush();
    test_clk_en();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
